// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally block.
//   state_t      : READY / LOCKOUT / RESULT controller states
//   DEF_*        : default candidate count and counter width
//   is_onehot    : exactly one bit set in a vector (up to 32 bits)
//   onehot_idx   : index of the set bit in a one-hot vector
package vote_pkg;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        LOCKOUT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    localparam int unsigned DEF_NUM_CAND = 4;
    localparam int unsigned DEF_CNT_W    = 8;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    function automatic int unsigned onehot_idx(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i[4:0]]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vote_counter_sat.sv
// Per-candidate saturating vote counter.
//   clock  in   system clock
//   reset  in   synchronous active-low reset
//   inc    in   count one vote this cycle
//   count  out  current count, sticks at all-ones
//   at_max out  count is at its maximum
module vote_counter_sat
    import vote_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    assign at_max = &count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vote_tally.sv
// Vote tally: counts one vote per accepted one-hot valid_vote pulse, rejects
// ambiguous or overflowing votes, holds off further votes for a lockout
// window, and reads back any candidate's count in result mode.
//   clock        in   system clock
//   reset        in   synchronous active-low reset
//   mode         in   0 = voting, 1 = result readout
//   valid_vote   in   one pulse bit per candidate
//   sel          in   candidate index for readout
//   vote_ack     out  1-cycle pulse, vote counted
//   vote_reject  out  1-cycle pulse, vote refused
//   busy         out  high while in lockout
//   result_count out  registered count of candidate sel (0 if out of range)
//   result_valid out  result_count valid (from 2nd RESULT cycle on)
//   total_votes  out  saturating sum of accepted votes
module vote_tally
    import vote_pkg::*;
#(
    parameter int unsigned NUM_CAND       = DEF_NUM_CAND,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned LOCKOUT_CYCLES = 200
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                mode,
    input  logic [NUM_CAND-1:0]                 valid_vote,
    input  logic [$clog2(NUM_CAND)-1:0]         sel,
    output logic                                vote_ack,
    output logic                                vote_reject,
    output logic                                busy,
    output logic [CNT_W-1:0]                    result_count,
    output logic                                result_valid,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total_votes
);

    localparam int unsigned SEL_W = $clog2(NUM_CAND);
    localparam int unsigned TOT_W = CNT_W + SEL_W;
    localparam int unsigned TMR_W = $clog2(LOCKOUT_CYCLES + 1);

    state_t               state;
    state_t               state_nxt;
    logic [TMR_W-1:0]     timer;
    logic [TMR_W-1:0]     timer_nxt;
    logic                 ack_nxt;
    logic                 rej_nxt;
    logic [NUM_CAND-1:0]  inc;
    logic [NUM_CAND-1:0]  at_max;
    logic                 single;
    logic                 target_full;
    logic [CNT_W-1:0]     cnt [NUM_CAND];
    logic [CNT_W-1:0]     acc [NUM_CAND+1];
    logic [CNT_W-1:0]     sel_count;

    // Counters plus an AND-OR readout chain; an out-of-range sel matches no
    // stage, so the chain yields zero.
    assign acc[0] = '0;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
        vote_counter_sat #(.CNT_W(CNT_W)) u_counter (
            .clock  (clock),
            .reset  (reset),
            .inc    (inc[g]),
            .count  (cnt[g]),
            .at_max (at_max[g])
        );
        assign acc[g+1] = acc[g] | ((sel == SEL_W'(g)) ? cnt[g] : '0);
    end

    assign sel_count   = acc[NUM_CAND];
    assign single      = is_onehot(32'(valid_vote));
    // With a single bit set, this picks that candidate's at_max flag.
    assign target_full = |(at_max & valid_vote);
    assign busy        = (state == LOCKOUT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= READY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        ack_nxt   = 1'b0;
        rej_nxt   = 1'b0;
        inc       = '0;
        case (state)
            READY: begin
                if (mode) begin
                    state_nxt = RESULT;
                end else if (single) begin
                    if (target_full) begin
                        rej_nxt = 1'b1;
                    end else begin
                        inc       = valid_vote;
                        ack_nxt   = 1'b1;
                        state_nxt = LOCKOUT;
                        timer_nxt = TMR_W'(LOCKOUT_CYCLES);
                    end
                end else if (valid_vote != '0) begin
                    rej_nxt = 1'b1;
                end
            end
            LOCKOUT: begin
                if (mode) begin
                    state_nxt = RESULT;
                    timer_nxt = '0;
                end else begin
                    // Leaving as the timer hits 0 gives exactly
                    // LOCKOUT_CYCLES cycles of busy.
                    timer_nxt = timer - TMR_W'(1);
                    if (timer == TMR_W'(1)) begin
                        state_nxt = READY;
                    end
                end
            end
            RESULT: begin
                if (!mode) begin
                    state_nxt = READY;
                end
            end
            default: begin
                state_nxt = READY;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            timer        <= '0;
            vote_ack     <= 1'b0;
            vote_reject  <= 1'b0;
            total_votes  <= '0;
            result_count <= '0;
            result_valid <= 1'b0;
        end else begin
            timer       <= timer_nxt;
            vote_ack    <= ack_nxt;
            vote_reject <= rej_nxt;
            if (ack_nxt && !(&total_votes)) begin
                total_votes <= total_votes + TOT_W'(1);
            end
            if (state == RESULT && mode) begin
                result_count <= sel_count;
                result_valid <= 1'b1;
            end else begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vote_tally.sv
module tb_vote_tally;

    logic       clock = 1'b0;
    logic       reset;

    // Main instance: defaults (4 candidates, 8-bit counters, 200-cycle lockout)
    logic       mode;
    logic [3:0] vv;
    logic [1:0] sel;
    logic       ack, rej, busy, rv;
    logic [7:0] rc;
    logic [9:0] tot;

    // Small instances: CNT_W=2, LOCKOUT_CYCLES=1; dut3 has 3 candidates
    logic       mode2;
    logic [3:0] vv2;
    logic [1:0] sel2;
    logic       ack2, rej2, busy2, rv2;
    logic [1:0] rc2;
    logic [3:0] tot2;
    logic       ack3, rej3, busy3, rv3;
    logic [1:0] rc3;
    logic [3:0] tot3;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    vote_tally dut (
        .clock(clock), .reset(reset), .mode(mode), .valid_vote(vv), .sel(sel),
        .vote_ack(ack), .vote_reject(rej), .busy(busy), .result_count(rc),
        .result_valid(rv), .total_votes(tot)
    );

    vote_tally #(.NUM_CAND(4), .CNT_W(2), .LOCKOUT_CYCLES(1)) dut2 (
        .clock(clock), .reset(reset), .mode(mode2), .valid_vote(vv2), .sel(sel2),
        .vote_ack(ack2), .vote_reject(rej2), .busy(busy2), .result_count(rc2),
        .result_valid(rv2), .total_votes(tot2)
    );

    vote_tally #(.NUM_CAND(3), .CNT_W(2), .LOCKOUT_CYCLES(1)) dut3 (
        .clock(clock), .reset(reset), .mode(mode2), .valid_vote(vv2[2:0]), .sel(sel2),
        .vote_ack(ack3), .vote_reject(rej3), .busy(busy3), .result_count(rc3),
        .result_valid(rv3), .total_votes(tot3)
    );

    typedef struct {
        logic       mode;
        logic [3:0] vv;
        logic [1:0] sel;
        logic       ack;
        logic       rej;
        logic       busy;
        logic       rv;
        logic [7:0] rc;
        logic [9:0] tot;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("wait_ready_busy", 32'(busy), 0);
    endtask

    task automatic cast(input int idx);
        vv = 4'(1 << idx);
        tick();
        chk($sformatf("cast%0d_ack", idx), 32'(ack), 1);
        vv = '0;
        wait_ready();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;

        // readout after counts {2,0,5,1}, total 8, result_count 0
        //          mode  vv       sel  ack rej busy rv  rc  tot
        tbl[0]  = '{1'b1, 4'b0000, 2'd0, 0, 0, 0, 0, 8'd0, 10'd8};
        tbl[1]  = '{1'b1, 4'b0000, 2'd0, 0, 0, 0, 1, 8'd2, 10'd8};
        tbl[2]  = '{1'b1, 4'b0000, 2'd1, 0, 0, 0, 1, 8'd0, 10'd8};
        tbl[3]  = '{1'b1, 4'b0000, 2'd2, 0, 0, 0, 1, 8'd5, 10'd8};
        tbl[4]  = '{1'b1, 4'b0000, 2'd3, 0, 0, 0, 1, 8'd1, 10'd8};
        tbl[5]  = '{1'b0, 4'b0000, 2'd2, 0, 0, 0, 0, 8'd1, 10'd8};
        tbl[6]  = '{1'b0, 4'b0100, 2'd0, 1, 0, 1, 0, 8'd1, 10'd9};
        tbl[7]  = '{1'b1, 4'b0000, 2'd2, 0, 0, 0, 0, 8'd1, 10'd9};
        tbl[8]  = '{1'b1, 4'b0000, 2'd2, 0, 0, 0, 1, 8'd6, 10'd9};
        tbl[9]  = '{1'b1, 4'b0001, 2'd2, 0, 0, 0, 1, 8'd6, 10'd9};
        tbl[10] = '{1'b0, 4'b0000, 2'd2, 0, 0, 0, 0, 8'd6, 10'd9};
        tbl[11] = '{1'b1, 4'b0001, 2'd0, 0, 0, 0, 0, 8'd6, 10'd9};
        tbl[12] = '{1'b1, 4'b0000, 2'd0, 0, 0, 0, 1, 8'd2, 10'd9};

        reset = 1'b0; mode = 1'b0; vv = '0; sel = '0;
        mode2 = 1'b0; vv2 = '0; sel2 = '0;
        tick(); tick();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rej", 32'(rej), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rv", 32'(rv), 0);
        chk("rst_rc", 32'(rc), 0);
        chk("rst_tot", 32'(tot), 0);
        reset = 1'b1;
        tick();

        // Small counter saturation: 3 acks then a reject on candidate 3
        for (int k = 0; k < 4; k++) begin
            vv2 = 4'b1000;
            tick();
            chk($sformatf("sat%0d_ack", k), 32'(ack2), (k < 3) ? 1 : 0);
            chk($sformatf("sat%0d_rej", k), 32'(rej2), (k < 3) ? 0 : 1);
            chk($sformatf("sat%0d_busy", k), 32'(busy2), (k < 3) ? 1 : 0);
            vv2 = '0;
            tick();
            chk($sformatf("sat%0d_busy_end", k), 32'(busy2), 0);
        end
        chk("sat_tot", 32'(tot2), 3);
        vv2 = 4'b0100;
        tick();
        chk("c2_ack2", 32'(ack2), 1);
        chk("c2_ack3", 32'(ack3), 1);
        vv2 = '0;
        mode2 = 1'b1; sel2 = 2'd3;
        tick();
        tick();
        chk("sat_rd3", 32'(rc2), 3);
        chk("oor_rd3", 32'(rc3), 0);
        chk("oor_rv", 32'(rv3), 1);
        sel2 = 2'd2;
        tick();
        chk("sat_rd2", 32'(rc2), 1);
        chk("small_rd2", 32'(rc3), 1);
        chk("small_tot", 32'(tot3), 1);
        mode2 = 1'b0;
        tick();

        // Accepted vote, lockout length, pulse ignored at lockout cycle 50
        vv = 4'b0010;
        tick();
        chk("t1_ack", 32'(ack), 1);
        chk("t1_rej", 32'(rej), 0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_tot", 32'(tot), 1);
        vv = '0;
        busy_n = 0;
        for (int c = 0; c < 300; c++) begin
            if (!busy) break;
            busy_n++;
            vv = (busy_n == 50) ? 4'b0001 : 4'b0000;
            tick();
            if (busy_n == 1) chk("t1_ack_pulse", 32'(ack), 0);
            if (busy_n == 50) begin
                chk("t2_lock_ack", 32'(ack), 0);
                chk("t2_lock_rej", 32'(rej), 0);
            end
        end
        vv = '0;
        chk("t1_lockout_len", 32'(busy_n), 200);
        chk("t2_lock_tot", 32'(tot), 1);
        vv = 4'b0001;
        tick();
        chk("t2_ack", 32'(ack), 1);
        chk("t2_tot", 32'(tot), 2);
        vv = '0;
        wait_ready();

        // Ambiguous vote
        vv = 4'b0110;
        tick();
        chk("t3_rej", 32'(rej), 1);
        chk("t3_ack", 32'(ack), 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_tot", 32'(tot), 2);
        vv = '0;
        tick();
        chk("t3_rej_pulse", 32'(rej), 0);

        // Reset in the middle of a lockout
        vv = 4'b0001;
        tick();
        chk("rl_ack", 32'(ack), 1);
        vv = '0;
        repeat (10) tick();
        chk("rl_busy_before", 32'(busy), 1);
        reset = 1'b0;
        tick();
        chk("rl_busy", 32'(busy), 0);
        chk("rl_tot", 32'(tot), 0);
        reset = 1'b1;

        // Build counts {2,0,5,1}
        cast(0); cast(0);
        for (int k = 0; k < 5; k++) cast(2);
        cast(3);

        for (int i = 0; i < 13; i++) begin
            mode = tbl[i].mode;
            vv   = tbl[i].vv;
            sel  = tbl[i].sel;
            tick();
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("v%0d_rej", i), 32'(rej), 32'(tbl[i].rej));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d_rv", i), 32'(rv), 32'(tbl[i].rv));
            chk($sformatf("v%0d_rc", i), 32'(rc), 32'(tbl[i].rc));
            chk($sformatf("v%0d_tot", i), 32'(tot), 32'(tbl[i].tot));
        end
        vv = '0;

        // Reset while in RESULT, then confirm counts cleared and READY
        reset = 1'b0;
        tick();
        chk("rr_rv", 32'(rv), 0);
        chk("rr_rc", 32'(rc), 0);
        chk("rr_tot", 32'(tot), 0);
        reset = 1'b1;
        mode = 1'b0;
        vv = 4'b0100;
        tick();
        chk("rr_ack", 32'(ack), 1);
        chk("rr_tot1", 32'(tot), 1);
        vv = '0;
        mode = 1'b1; sel = 2'd2;
        tick();
        chk("rr_abort_busy", 32'(busy), 0);
        tick();
        chk("rr_rc2", 32'(rc), 1);
        chk("rr_rv2", 32'(rv), 1);
        mode = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
